// File: rtl/prog_launcher_if.sv
// Bus bundle between the program launcher and its surroundings: host word
// stream, instruction-memory write port, core control and run results.
// The master modport is the launcher's view; slave is the host/core/memory side.
interface prog_launcher_if #(
    parameter int D = 12,
    parameter int W = 9,
    parameter int C = 16
);
    // Four-phase start handshake with the host
    logic         req;
    logic         ack;

    // Host machine-code stream (valid/ready)
    logic         host_valid;
    logic         host_ready;
    logic [W-1:0] host_data;
    logic         host_last;

    // Instruction memory write port
    logic         imem_wr_en;
    logic [D-1:0] imem_wr_addr;
    logic [W-1:0] imem_wr_data;

    // Core control and status
    logic         core_reset;
    logic         core_done;

    // Results of the most recent run
    logic [D:0]   load_count;
    logic [C-1:0] cycle_count;
    logic         timeout;

    modport master (
        input  req,
        input  host_valid,
        input  host_data,
        input  host_last,
        input  core_done,
        output ack,
        output host_ready,
        output imem_wr_en,
        output imem_wr_addr,
        output imem_wr_data,
        output core_reset,
        output load_count,
        output cycle_count,
        output timeout
    );

    modport slave (
        output req,
        output host_valid,
        output host_data,
        output host_last,
        output core_done,
        input  ack,
        input  host_ready,
        input  imem_wr_en,
        input  imem_wr_addr,
        input  imem_wr_data,
        input  core_reset,
        input  load_count,
        input  cycle_count,
        input  timeout
    );
endinterface

// File: rtl/prog_launcher.sv
// Purpose: load a program into instruction memory, pulse core reset, run the core and time it.
// Latency: memory write one cycle after each accepted host word; ack one cycle after done/limit.
// Backpressure: host_ready is high only while loading; host_valid=0 stalls the load indefinitely.
//
// Ports:
//   clk, reset  - single clock, synchronous active-high reset
//   bus.req/ack - four-phase start request / run-finished acknowledge
//   bus.host_*  - valid/ready stream of W-bit machine-code words, host_last ends the program
//   bus.imem_*  - registered write port into instruction memory
//   bus.core_*  - reset drive to the core and its done flag
//   bus.load_count/cycle_count/timeout - results of the last load and run, held until next req
module prog_launcher #(
    parameter int D       = 12,
    parameter int W       = 9,
    parameter int RST_CYC = 2,
    parameter int MAX_CYC = 4096,
    parameter int C       = 16
) (
    input  logic              clk,
    input  logic              reset,
    prog_launcher_if.master   bus
);

    // Hold counter only has to reach RST_CYC-1; RST_CYC is at least 1.
    localparam int HW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYC - 1);
    localparam logic [C-1:0]  CYC_LAST  = C'(MAX_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_FINISH
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [D-1:0]  addr;
    logic [HW-1:0] hold_cnt;

    logic          ack_q;
    logic          imem_wr_en_q;
    logic [D-1:0]  imem_wr_addr_q;
    logic [W-1:0]  imem_wr_data_q;
    logic          core_reset_q;
    logic [D:0]    load_count_q;
    logic [C-1:0]  cycle_count_q;
    logic          timeout_q;

    logic          accept;
    logic          load_end;
    logic          run_limit;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load_end  = 1'b0;
        run_limit = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (bus.req) begin
                    state_nxt = S_LOAD;
                end
            end

            S_LOAD: begin
                // req is deliberately not looked at here.
                accept = bus.host_valid;
                // The top address is the last slot: loading stops there even
                // without host_last so the address never wraps over word 0.
                load_end = accept && (bus.host_last || (addr == {D{1'b1}}));
                if (load_end) begin
                    state_nxt = S_HOLD;
                end
            end

            S_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                // done has priority over the cycle limit.
                if (bus.core_done) begin
                    state_nxt = S_FINISH;
                end else if (cycle_count_q == CYC_LAST) begin
                    run_limit = 1'b1;
                    state_nxt = S_FINISH;
                end
            end

            S_FINISH: begin
                if (!bus.req) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            addr           <= '0;
            hold_cnt       <= '0;
            ack_q          <= 1'b0;
            imem_wr_en_q   <= 1'b0;
            imem_wr_addr_q <= '0;
            imem_wr_data_q <= '0;
            core_reset_q   <= 1'b1;
            load_count_q   <= '0;
            cycle_count_q  <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state <= state_nxt;

            // Registered from the next state so ack and core_reset change
            // in the same cycle as the state they describe.
            ack_q        <= (state_nxt == S_FINISH);
            core_reset_q <= (state_nxt != S_RUN);

            // Write strobe is exactly one cycle per accepted word; address and
            // data hold their last values when idle.
            imem_wr_en_q <= accept;
            if (accept) begin
                imem_wr_addr_q <= addr;
                imem_wr_data_q <= bus.host_data;
                addr           <= addr + 1'b1;
                load_count_q   <= load_count_q + 1'b1;
            end

            unique case (state)
                S_IDLE: begin
                    // Results of the previous run stay visible until a new
                    // request starts the next load.
                    if (bus.req) begin
                        addr          <= '0;
                        load_count_q  <= '0;
                        cycle_count_q <= '0;
                        timeout_q     <= 1'b0;
                    end
                end

                S_LOAD: begin
                    // Arm the hold counter so HOLD lasts RST_CYC cycles from entry.
                    hold_cnt <= '0;
                end

                S_HOLD: begin
                    hold_cnt <= hold_cnt + 1'b1;
                end

                S_RUN: begin
                    // The done cycle is not counted; the limit cycle is, which
                    // leaves cycle_count at exactly MAX_CYC on timeout.
                    if (!bus.core_done) begin
                        cycle_count_q <= cycle_count_q + 1'b1;
                    end
                    if (run_limit) begin
                        timeout_q <= 1'b1;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // host_ready is combinational from state so the first LOAD cycle can accept.
    assign bus.host_ready   = (state == S_LOAD);
    assign bus.ack          = ack_q;
    assign bus.imem_wr_en   = imem_wr_en_q;
    assign bus.imem_wr_addr = imem_wr_addr_q;
    assign bus.imem_wr_data = imem_wr_data_q;
    assign bus.core_reset   = core_reset_q;
    assign bus.load_count   = load_count_q;
    assign bus.cycle_count  = cycle_count_q;
    assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_prog_launcher.sv
module tb_prog_launcher;

    localparam int D       = 4;
    localparam int W       = 9;
    localparam int RST_CYC = 2;
    localparam int MAX_CYC = 32;
    localparam int C       = 16;
    localparam int DEPTH   = 1 << D;

    typedef struct packed {
        logic [D-1:0] addr;
        logic [W-1:0] data;
    } wr_t;

    typedef struct packed {
        logic [D:0]   lc;
        logic [C-1:0] cc;
        logic         to;
    } res_t;

    logic clk;
    logic reset;

    prog_launcher_if #(.D(D), .W(W), .C(C)) bus ();

    prog_launcher #(
        .D(D), .W(W), .RST_CYC(RST_CYC), .MAX_CYC(MAX_CYC), .C(C)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    wr_t  wr_q[$];
    res_t res_q[$];
    logic [W-1:0] prog [0:31];
    logic ack_prev = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every write and every ack rising edge is matched against the scoreboard.
    always @(negedge clk) begin
        wr_t  ew;
        res_t er;
        if (bus.imem_wr_en === 1'b1) begin
            chk("write_expected", 32'(wr_q.size() > 0), 1);
            if (wr_q.size() > 0) begin
                ew = wr_q.pop_front();
                chk("wr_addr", 32'(bus.imem_wr_addr), 32'(ew.addr));
                chk("wr_data", 32'(bus.imem_wr_data), 32'(ew.data));
            end
        end
        if (bus.ack === 1'b1 && ack_prev !== 1'b1) begin
            chk("result_expected", 32'(res_q.size() > 0), 1);
            if (res_q.size() > 0) begin
                er = res_q.pop_front();
                chk("load_count", 32'(bus.load_count), 32'(er.lc));
                chk("cycle_count", 32'(bus.cycle_count), 32'(er.cc));
                chk("timeout", 32'(bus.timeout), 32'(er.to));
                chk("core_reset_finish", 32'(bus.core_reset), 1);
            end
        end
        ack_prev = bus.ack;
    end

    // Reference: a run whose done flag is seen after k counted cycles reports k,
    // unless k reaches the limit, in which case it reports the limit and timeout.
    function automatic res_t model(input int n, input int k);
        res_t r;
        r.lc = (D+1)'((n < DEPTH) ? n : DEPTH);
        r.cc = C'((k < MAX_CYC) ? k : MAX_CYC);
        r.to = (k >= MAX_CYC);
        return r;
    endfunction

    // vmode: 0 steady valid, 1 random valid/req/done noise, 2 pattern 1,0,0,1,1, 3 ten-cycle stall first
    task automatic run_one(input int n, input int vmode, input int k, input bit rst_mid);
        int   idx;
        int   pcnt;
        int   guard;
        bit   fin;
        logic v;
        res_t exp_r;
        logic [4:0] pat;
        pat   = 5'b11001;   // bit i is the valid value of cycle i
        exp_r = model(n, k);
        if (!rst_mid) res_q.push_back(exp_r);

        bus.req = 1'b1;
        @(negedge clk);
        chk("ready_in_load", 32'(bus.host_ready), 1);

        idx = 0; pcnt = 0; guard = 0; fin = 1'b0;
        while (!fin && guard < 400) begin
            case (vmode)
                1:       v = 1'($urandom_range(0, 1));
                2:       v = (pcnt < 5) ? pat[pcnt] : 1'b1;
                3:       v = (pcnt >= 10);
                default: v = 1'b1;
            endcase
            if (vmode == 1) begin
                bus.req       = 1'($urandom_range(0, 1));
                bus.core_done = 1'($urandom_range(0, 1));
            end
            bus.host_valid = v;
            bus.host_data  = prog[idx];
            bus.host_last  = (idx == n - 1);
            if (v && bus.host_ready) begin
                wr_q.push_back('{addr: D'(idx), data: prog[idx]});
                idx++;
                if (idx == n || idx == DEPTH) fin = 1'b1;
            end
            pcnt++;
            @(negedge clk);
            guard++;
            if (vmode == 3 && pcnt == 10) chk("stall_keeps_load", 32'(bus.host_ready), 1);
        end
        chk("load_completes", 32'(fin), 1);

        // First HOLD cycle: a further word is offered and must be ignored.
        bus.req        = 1'b1;
        bus.core_done  = 1'b0;
        bus.host_valid = 1'b1;
        bus.host_data  = prog[idx];
        bus.host_last  = 1'b0;
        chk("ready_drops", 32'(bus.host_ready), 0);
        chk("core_reset_hold0", 32'(bus.core_reset), 1);
        for (int h = 1; h < RST_CYC; h++) begin
            @(negedge clk);
            chk("core_reset_hold", 32'(bus.core_reset), 1);
        end
        @(negedge clk);
        bus.host_valid = 1'b0;
        chk("core_reset_run", 32'(bus.core_reset), 0);

        if (rst_mid) begin
            repeat (5) @(negedge clk);
            chk("run_count_5", 32'(bus.cycle_count), 5);
            reset = 1'b1;
            @(negedge clk);
            reset   = 1'b0;
            bus.req = 1'b0;
            chk("rst_ack", 32'(bus.ack), 0);
            chk("rst_core_reset", 32'(bus.core_reset), 1);
            chk("rst_cycle_count", 32'(bus.cycle_count), 0);
            chk("rst_load_count", 32'(bus.load_count), 0);
            chk("rst_timeout", 32'(bus.timeout), 0);
            chk("rst_ready", 32'(bus.host_ready), 0);
            @(negedge clk);
            chk("rst_stays_idle", 32'(bus.host_ready), 0);
            return;
        end

        for (int i = 0; i < k && !bus.ack; i++) @(negedge clk);
        if (!bus.ack) bus.core_done = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus.ack && guard < MAX_CYC + 10);
        chk("ack_arrives", 32'(bus.ack), 1);
        bus.core_done = 1'b0;

        // done pulse in FINISH must not disturb the frozen results.
        @(negedge clk);
        bus.core_done = 1'b1;
        @(negedge clk);
        bus.core_done = 1'b0;
        chk("finish_ack_held", 32'(bus.ack), 1);
        chk("finish_cc_frozen", 32'(bus.cycle_count), 32'(exp_r.cc));
        chk("finish_to_frozen", 32'(bus.timeout), 32'(exp_r.to));

        bus.req = 1'b0;
        @(negedge clk);
        chk("idle_ack_low", 32'(bus.ack), 0);
        chk("idle_core_reset", 32'(bus.core_reset), 1);
        chk("idle_lc_kept", 32'(bus.load_count), 32'(exp_r.lc));
        chk("idle_cc_kept", 32'(bus.cycle_count), 32'(exp_r.cc));
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        bus.req        = 1'b0;
        bus.host_valid = 1'b0;
        bus.host_data  = '0;
        bus.host_last  = 1'b0;
        bus.core_done  = 1'b0;
        for (int i = 0; i < 32; i++) prog[i] = W'($urandom);

        repeat (2) @(negedge clk);
        chk("reset_ack", 32'(bus.ack), 0);
        chk("reset_ready", 32'(bus.host_ready), 0);
        chk("reset_wr_en", 32'(bus.imem_wr_en), 0);
        chk("reset_wr_addr", 32'(bus.imem_wr_addr), 0);
        chk("reset_wr_data", 32'(bus.imem_wr_data), 0);
        chk("reset_core_reset", 32'(bus.core_reset), 1);
        chk("reset_load_count", 32'(bus.load_count), 0);
        chk("reset_cycle_count", 32'(bus.cycle_count), 0);
        chk("reset_timeout", 32'(bus.timeout), 0);
        reset = 1'b0;
        bus.core_done = 1'b1;       // ignored outside RUN
        @(negedge clk);
        bus.core_done = 1'b0;
        chk("idle_ready", 32'(bus.host_ready), 0);

        prog[0] = 9'h0A1; prog[1] = 9'h1F3; prog[2] = 9'h002; prog[3] = 9'h1FF;
        run_one(4, 0, 20, 1'b0);
        run_one(3, 2, 7, 1'b0);
        run_one(5, 3, MAX_CYC + 5, 1'b0);
        run_one(2, 0, MAX_CYC - 1, 1'b0);
        for (int i = 0; i < 32; i++) prog[i] = W'($urandom);
        run_one(20, 0, 3, 1'b0);
        run_one(6, 0, 0, 1'b1);
        run_one(1, 0, 0, 1'b0);
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 32; i++) prog[i] = W'($urandom);
            run_one($urandom_range(1, 10), $urandom_range(0, 1), $urandom_range(0, MAX_CYC + 2), 1'b0);
        end

        repeat (4) @(negedge clk);
        chk("wr_queue_drained", 32'(wr_q.size()), 0);
        chk("res_queue_drained", 32'(res_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
